// File: rtl/axi_lite_mem_slave_if.sv
// axi_lite_mem_slave_if: AXI4-Lite bus bundle between an initiator (master) and a responder (slave).
interface axi_lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: single-outstanding AXI4-Lite responder backed by a byte-wide memory.
module axi_lite_mem_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4096
) (
  input logic aclk,
  input logic areset,
  axi_lite_mem_slave_if.slave s
);
  localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] OKAY = 2'b00, DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;
  state_t                state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d, bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  ar_ok, w_ok;
  // one extra bit keeps the compare correct when MEM_DEPTH == 2**ADDR_WIDTH
  assign ar_ok = {1'b0, s.araddr} < (ADDR_WIDTH+1)'(MEM_DEPTH);
  assign w_ok  = {1'b0, addr_q} < (ADDR_WIDTH+1)'(MEM_DEPTH);
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        if (s.arvalid && (!s.awvalid || last_wr_q)) begin
          state_d   = RADDR;
          last_wr_d = 1'b0;
        end else if (s.awvalid) begin
          state_d   = WADDR;
          last_wr_d = 1'b1;
        end
      end
      RADDR: begin
        state_d = RDATA;
        addr_d  = s.araddr;
        rdata_d = ar_ok ? mem[s.araddr[MW-1:0]] : '0;
        rresp_d = ar_ok ? OKAY : DECERR;
      end
      RDATA: state_d = s.rready ? IDLE : RDATA;
      WADDR: begin
        state_d = WDATA;
        addr_d  = s.awaddr;
      end
      WDATA: begin
        if (s.wvalid) begin
          state_d = WRESP;
          bresp_d = w_ok ? OKAY : DECERR;
        end
      end
      WRESP: state_d = s.bready ? IDLE : WRESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      addr_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      bresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end
  always_ff @(posedge aclk) begin
    if (!areset && state_q == WDATA && s.wvalid && w_ok && s.wstrb[0]) mem[addr_q[MW-1:0]] <= s.wdata;
  end
  assign s.arready = state_q == RADDR;
  assign s.rvalid  = state_q == RDATA;
  assign s.awready = state_q == WADDR;
  assign s.wready  = state_q == WDATA;
  assign s.bvalid  = state_q == WRESP;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed AXI-Lite transactions; expected responses queued and checked by monitors.
module tb_axi_lite_mem_slave;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  logic [9:0] rq [$];
  logic [1:0] bq [$];
  logic [7:0] gq [$];
  axi_lite_mem_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();
  axi_lite_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(16)) dut (
    .aclk(aclk), .areset(areset), .s(bus.slave)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sel(input int k);
    case (k)
      0: return bus.arready;
      1: return bus.rvalid;
      2: return bus.awready;
      3: return bus.wready;
      default: return bus.bvalid;
    endcase
  endfunction

  task automatic wait_for(input int k, input string nm);
    for (int i = 0; i <= 50; i++) begin
      @(negedge aclk);
      if (sel(k)) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] d, input logic [1:0] r, input int hold, input bit lat);
    int t0;
    rq.push_back({d, r});
    @(posedge aclk); #1;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    t0 = cyc;
    wait_for(0, "ar_wait");
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    bus.rready = (hold == 0);
    wait_for(1, "r_wait");
    if (lat) chk("rd_latency", cyc - t0, 2);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge aclk); #1;
        bus.arvalid = 1'b1;
        @(negedge aclk);
        chk("hold_rvalid", bus.rvalid, 1);
        chk("hold_rdata", bus.rdata, d);
        chk("hold_rresp", bus.rresp, r);
        chk("hold_arready", bus.arready, 0);
      end
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
    end
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d, input logic s, input logic [1:0] r);
    bq.push_back(r);
    @(posedge aclk); #1;
    bus.awaddr = a;
    bus.awvalid = 1'b1;
    wait_for(2, "aw_wait");
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wvalid = 1'b1;
    wait_for(3, "w_wait");
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    wait_for(4, "b_wait");
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          logic [9:0] e;
          e = rq.pop_front();
          chk("rdata", bus.rdata, e[9:2]);
          chk("rresp", bus.rresp, e[1:0]);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", bus.bresp, bq.pop_front());
      end
      if (bus.arready && gq.size() != 0) chk("grant", 8'h52, gq.pop_front());
      if (bus.awready && gq.size() != 0) chk("grant", 8'h57, gq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    #1;
    chk("rst_arready", bus.arready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_bresp", bus.bresp, 0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    wr(12'h004, 8'hA5, 1'b1, 2'b00);
    rd(12'h004, 8'hA5, 2'b00, 0, 1'b1);
    rd(12'h004, 8'hA5, 2'b00, 3, 1'b0);
    pulse_reset();
    gq.push_back(8'h52); gq.push_back(8'h57);
    fork
      rd(12'h004, 8'hA5, 2'b00, 0, 1'b0);
      wr(12'h014, 8'h3C, 1'b1, 2'b11);
    join
    gq.push_back(8'h52);
    rd(12'h004, 8'hA5, 2'b00, 0, 1'b0);
    gq.push_back(8'h57); gq.push_back(8'h52);
    fork
      wr(12'h00F, 8'h5A, 1'b1, 2'b00);
      rd(12'h004, 8'hA5, 2'b00, 0, 1'b0);
    join
    rd(12'h00F, 8'h5A, 2'b00, 0, 1'b0);
    wr(12'h014, 8'h77, 1'b1, 2'b11);
    rd(12'h014, 8'h00, 2'b11, 0, 1'b0);
    wr(12'h010, 8'h66, 1'b1, 2'b11);
    rd(12'h010, 8'h00, 2'b11, 0, 1'b0);
    rd(12'h004, 8'hA5, 2'b00, 0, 1'b0);
    wr(12'h004, 8'h11, 1'b1, 2'b00);
    wr(12'h004, 8'hFF, 1'b0, 2'b00);
    rd(12'h004, 8'h11, 2'b00, 0, 1'b0);
    @(posedge aclk); #1;
    bus.awaddr = 12'h004;
    bus.awvalid = 1'b1;
    wait_for(2, "abort_aw_wait");
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    bus.wdata = 8'hEE;
    bus.wstrb = 1'b1;
    wait_for(3, "abort_w_wait");
    #1 areset = 1'b1;
    #1;
    chk("abort_wready", bus.wready, 0);
    chk("abort_awready", bus.awready, 0);
    chk("abort_bvalid", bus.bvalid, 0);
    chk("abort_rvalid", bus.rvalid, 0);
    chk("abort_arready", bus.arready, 0);
    chk("abort_rdata", bus.rdata, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    rd(12'h004, 8'h11, 2'b00, 0, 1'b0);
    repeat (3) @(posedge aclk);
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    chk("gq_drained", gq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI4-Lite responder (slave) that terminates the initiator-side bus defined by the team's AXI-Lite package.
- Backs the address space with a byte-wide register-file memory.
- Serves one transaction at a time through a single FSM (IDLE, RADDR, RDATA, WADDR, WDATA, WRESP) and returns OKAY or DECERR.
- Sits behind the interconnect as the DUT-side endpoint and is the memory model the scoreboard mirrors.

Parameters:
- ADDR_WIDTH, 12, address bits on the AR/AW channels.
- DATA_WIDTH, 8, data bits on the R/W channels; STRB_WIDTH = DATA_WIDTH/8.
- MEM_DEPTH, 4096, number of implemented locations (≤ 2**ADDR_WIDTH); addresses ≥ MEM_DEPTH decode-error.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  write byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (areset=1, async): state=IDLE; arready, rvalid, awready, wready, bvalid = 0; rdata = 0; rresp, bresp = OKAY (2'b00); last_grant = WRITE; captured address regs = 0. Memory contents are not cleared by reset (power-up undefined). Reset asserted mid-transaction aborts it immediately; an in-flight write whose W handshake has not completed is not committed.
- All outputs are registered, Moore-style decodes of state.
- IDLE, arbitration:
  - arvalid only -> RADDR; awvalid only -> WADDR.
  - Both valid -> grant the type not granted last (round-robin); last_grant updates on every grant.
  - Neither -> stay in IDLE.
  - After reset the first simultaneous request goes to read.
- RADDR: arready=1 for exactly one cycle. araddr is captured on that edge (arvalid is guaranteed high since it was high in IDLE). -> RDATA.
- RDATA: rvalid=1.
  - rdata = mem[addr] and rresp = OKAY if addr < MEM_DEPTH; otherwise rdata = 0, rresp = DECERR (2'b11).
  - rdata and rresp are stable while rvalid=1 and rready=0.
  - On rvalid&&rready -> IDLE.
- WADDR: awready=1 for one cycle; awaddr captured. -> WDATA.
- WDATA: wready=1 until wvalid.
  - On wvalid&&wready: if addr < MEM_DEPTH and wstrb[0]=1, mem[addr] <= wdata; wstrb=0 writes nothing.
  - Set bresp = OKAY, or DECERR if out of range (no write). -> WRESP.
  - W data presented before the AW handshake is held by the initiator and accepted only in WDATA.
- WRESP: bvalid=1 with bresp stable until bready; on bvalid&&bready -> IDLE.
- Latency:
  - Read: arvalid high at edge N (in IDLE) -> arready in cycle N+1 -> rvalid in cycle N+2.
  - Write: awvalid at edge N -> awready at N+1 -> wready at N+2 -> bvalid the cycle after the W handshake.
  - Back-to-back transactions incur one IDLE cycle between them.
- No outstanding transactions; ready signals never assert outside their state; no combinational input-to-output paths.
- Read after write to the same address returns the new data (the write commits before WRESP).

Test Plan:
- Write 0xA5 to addr0 (0x004), bready=1; read 0x004 -> bresp=OKAY; rdata=0xA5, rresp=OKAY; rvalid asserted 2 cycles after arvalid is sampled.
- Hold rready=0 for 3 cycles after rvalid -> rvalid stays 1, rdata/rresp unchanged, arready stays 0 even with a new arvalid; completes on the cycle rready=1.
- After reset, raise arvalid (0x004) and awvalid (addr1 0x014, wdata 0x3C) on the same cycle -> read granted first, write next; then a second simultaneous pair -> write granted first.
- MEM_DEPTH=16: write 0x77 to 0x014, then read 0x014 -> bresp=DECERR, rresp=DECERR, rdata=0x00; mem[0x004] unchanged.
- Write 0xFF to 0x004 with wstrb=0 after writing 0x11 -> bresp=OKAY; readback 0x11.
- Assert areset during WDATA (before wvalid) -> all outputs 0 on the same edge/asynchronously, state IDLE; a later read of the target address returns its pre-transaction value.
